// File: rtl/fifo8x9_pkg.sv
// Shared sizing, FSM states and storage strobe bundle
// for the FIFO8x9 control stage.
package fifo8x9_pkg;

    localparam int DEPTH      = 8;
    localparam int PTR_W      = 3;
    localparam int CNT_W      = 4;
    localparam int AFULL_LVL  = 6;
    localparam int AEMPTY_LVL = 2;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef struct packed {
        logic en;
        logic inc;
        logic clr;
    } strobe_t;

endpackage

// File: rtl/fifo8x9_if.sv
// Handshake, storage strobe and status bundle between
// the FIFO8x9 control stage and its users.
interface fifo8x9_if;
    import fifo8x9_pkg::*;

    logic             push_req;
    logic             push_ready;
    logic             pop_req;
    logic             pop_ready;
    logic             flush;
    logic             err_clr;
    logic             wren;
    logic             WrInc;
    logic             WrPtrClr;
    logic             rden;
    logic             RdInc;
    logic             RdPtrClr;
    logic             rd_valid;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output push_req, pop_req, flush, err_clr,
        input  push_ready, pop_ready,
        input  wren, WrInc, WrPtrClr,
        input  rden, RdInc, RdPtrClr,
        input  rd_valid, count, full, empty,
        input  almost_full, almost_empty,
        input  overflow, underflow
    );

    modport slave (
        input  push_req, pop_req, flush, err_clr,
        output push_ready, pop_ready,
        output wren, WrInc, WrPtrClr,
        output rden, RdInc, RdPtrClr,
        output rd_valid, count, full, empty,
        output almost_full, almost_empty,
        output overflow, underflow
    );

endinterface

// File: rtl/fifo8x9_ptr_side.sv
// One side (write or read) of the storage pointer mirror:
// pointer, wrap pending bit and strobe generation.
module fifo_ptr_side
    import fifo8x9_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    init,
    input  logic    flush,
    input  logic    fire,
    output logic    pend,
    output strobe_t stb
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr;

    // The storage pointer cannot wrap, so the last slot
    // holds it and the clear is issued on the next cycle.
    always_comb begin
        stb     = '0;
        stb.en  = fire;
        stb.inc = fire && (ptr != LAST);
        stb.clr = init || pend;
    end

    always_ff @(posedge clk) begin
        if (rst || init || flush) begin
            ptr  <= '0;
            pend <= 1'b0;
        end else if (pend) begin
            ptr  <= '0;
            pend <= 1'b0;
        end else if (fire) begin
            if (ptr == LAST) begin
                pend <= 1'b1;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo8x9_ctrl.sv
// Control stage for the 8x9 FIFO storage: handshakes,
// occupancy, flags, sticky errors and pointer wrap.
module fifo8x9_ctrl
    import fifo8x9_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    fifo8x9_if.slave bus
);

    state_t           state;
    state_t           state_n;
    logic             run;
    logic             push_ready;
    logic             pop_ready;
    logic             push_fire;
    logic             pop_fire;
    logic             wpend;
    logic             rpend;
    strobe_t          wstb;
    strobe_t          rstb;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_n;
    logic             full_q;
    logic             empty_q;
    logic             afull_q;
    logic             aempty_q;
    logic             rd_valid_q;
    logic             ovf_q;
    logic             unf_q;
    logic             ovf_evt;
    logic             unf_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        push_ready = 1'b0;
        pop_ready  = 1'b0;
        unique case (state)
            INIT: state_n = RUN;
            RUN: begin
                if (bus.flush) state_n = INIT;
                push_ready = !full_q && !wpend && !bus.flush;
                pop_ready  = !empty_q && !rpend && !bus.flush;
            end
            default: state_n = INIT;
        endcase
    end

    assign run       = (state == RUN);
    assign push_fire = bus.push_req && push_ready;
    assign pop_fire  = bus.pop_req && pop_ready;
    assign ovf_evt   = run && !bus.flush
                       && bus.push_req && !push_ready;
    assign unf_evt   = !bus.flush && bus.pop_req && empty_q;

    fifo_ptr_side u_wr (
        .clk   (clk),
        .rst   (rst),
        .init  (!run),
        .flush (bus.flush),
        .fire  (push_fire),
        .pend  (wpend),
        .stb   (wstb)
    );

    fifo_ptr_side u_rd (
        .clk   (clk),
        .rst   (rst),
        .init  (!run),
        .flush (bus.flush),
        .fire  (pop_fire),
        .pend  (rpend),
        .stb   (rstb)
    );

    always_comb begin
        count_n = count_q;
        if (!run || bus.flush) begin
            count_n = '0;
        end else if (push_fire && !pop_fire) begin
            count_n = count_q + 1'b1;
        end else if (pop_fire && !push_fire) begin
            count_n = count_q - 1'b1;
        end
    end

    // Flags are registered from the next count so they
    // line up with count itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            afull_q    <= 1'b0;
            aempty_q   <= 1'b1;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            count_q    <= count_n;
            full_q     <= (count_n == CNT_W'(DEPTH));
            empty_q    <= (count_n == '0);
            afull_q    <= (count_n >= CNT_W'(AFULL_LVL));
            aempty_q   <= (count_n <= CNT_W'(AEMPTY_LVL));
            rd_valid_q <= pop_fire;
            ovf_q      <= ovf_evt || (ovf_q && !bus.err_clr);
            unf_q      <= unf_evt || (unf_q && !bus.err_clr);
        end
    end

    assign bus.push_ready   = push_ready;
    assign bus.pop_ready    = pop_ready;
    assign bus.wren         = wstb.en;
    assign bus.WrInc        = wstb.inc;
    assign bus.WrPtrClr     = wstb.clr;
    assign bus.rden         = rstb.en;
    assign bus.RdInc        = rstb.inc;
    assign bus.RdPtrClr     = rstb.clr;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Bench for fifo8x9_ctrl: vector table plus corner sequences,
// with a storage model and a data scoreboard.
module tb_fifo8x9_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo8x9_if bus ();

    fifo8x9_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int rv_seen = 0;

    // in = {rst, flush, err_clr, push_req, pop_req}
    // exp strobes = {push_ready, pop_ready, wren, WrInc,
    //   WrPtrClr, rden, RdInc, RdPtrClr, rd_valid}
    // exp flags = {full, empty, afull, aempty, ovf, unf}
    typedef struct {
        logic [4:0]  in;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[$];

    logic [8:0] mem [8];
    logic [2:0] wp;
    logic [2:0] rp;
    logic [8:0] dout;
    logic [8:0] nv = 9'h001;
    logic [8:0] exp_q[$];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic row(input logic [4:0] in,
                       input logic [8:0] strb,
                       input logic [5:0] flg,
                       input logic [3:0] cnt);
        vec_t v;
        v.in  = in;
        v.exp = {strb, flg, cnt};
        tbl.push_back(v);
    endtask

    task automatic set_in(input logic [4:0] in);
        rst          = in[4];
        bus.flush    = in[3];
        bus.err_clr  = in[2];
        bus.push_req = in[1];
        bus.pop_req  = in[0];
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] outs();
        return {bus.push_ready, bus.pop_ready, bus.wren,
                bus.WrInc, bus.WrPtrClr, bus.rden, bus.RdInc,
                bus.RdPtrClr, bus.rd_valid, bus.full, bus.empty,
                bus.almost_full, bus.almost_empty,
                bus.overflow, bus.underflow, bus.count};
    endfunction

    // Behavioural FIFO8x9 storage driven by the strobes.
    always @(posedge clk) begin
        if (bus.wren) mem[wp] <= nv;
        if (bus.WrPtrClr) wp <= '0;
        else if (bus.WrInc) wp <= wp + 3'd1;
        if (bus.rden) dout <= mem[rp];
        if (bus.RdPtrClr) rp <= '0;
        else if (bus.RdInc) rp <= rp + 3'd1;
    end

    always @(posedge clk) begin
        if (rst || bus.flush) begin
            exp_q.delete();
        end else if (bus.wren) begin
            exp_q.push_back(nv);
            nv <= nv + 9'd1;
        end
    end

    always @(negedge clk) begin
        if (bus.rd_valid) begin
            rv_seen++;
            if (exp_q.size() == 0) begin
                chk("data_unexpected", {23'd0, dout}, 32'hFFFF_FFFF);
            end else begin
                chk("data", {23'd0, dout}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    int wclr_n;
    int rclr_n;
    int clash;
    logic [18:0] rst_exp;

    initial begin
        rst_exp = {9'b0_0_0_0_1_0_0_1_0, 6'b0_1_0_1_0_0, 4'd0};
        // reset and INIT
        row(5'b10000, 9'b0_0_0_0_1_0_0_1_0, 6'b0_1_0_1_0_0, 4'd0);
        row(5'b10000, 9'b0_0_0_0_1_0_0_1_0, 6'b0_1_0_1_0_0, 4'd0);
        row(5'b00000, 9'b0_0_0_0_1_0_0_1_0, 6'b0_1_0_1_0_0, 4'd0);
        // fill
        row(5'b00010, 9'b1_0_1_1_0_0_0_0_0, 6'b0_1_0_1_0_0, 4'd0);
        row(5'b00010, 9'b1_1_1_1_0_0_0_0_0, 6'b0_0_0_1_0_0, 4'd1);
        row(5'b00010, 9'b1_1_1_1_0_0_0_0_0, 6'b0_0_0_1_0_0, 4'd2);
        row(5'b00010, 9'b1_1_1_1_0_0_0_0_0, 6'b0_0_0_0_0_0, 4'd3);
        row(5'b00010, 9'b1_1_1_1_0_0_0_0_0, 6'b0_0_0_0_0_0, 4'd4);
        row(5'b00010, 9'b1_1_1_1_0_0_0_0_0, 6'b0_0_0_0_0_0, 4'd5);
        row(5'b00010, 9'b1_1_1_1_0_0_0_0_0, 6'b0_0_1_0_0_0, 4'd6);
        row(5'b00010, 9'b1_1_1_0_0_0_0_0_0, 6'b0_0_1_0_0_0, 4'd7);
        row(5'b00010, 9'b0_1_0_0_1_0_0_0_0, 6'b1_0_1_0_0_0, 4'd8);
        row(5'b00000, 9'b0_1_0_0_0_0_0_0_0, 6'b1_0_1_0_1_0, 4'd8);
        // drain
        row(5'b00001, 9'b0_1_0_0_0_1_1_0_0, 6'b1_0_1_0_1_0, 4'd8);
        row(5'b00001, 9'b1_1_0_0_0_1_1_0_1, 6'b0_0_1_0_1_0, 4'd7);
        row(5'b00001, 9'b1_1_0_0_0_1_1_0_1, 6'b0_0_1_0_1_0, 4'd6);
        row(5'b00001, 9'b1_1_0_0_0_1_1_0_1, 6'b0_0_0_0_1_0, 4'd5);
        row(5'b00001, 9'b1_1_0_0_0_1_1_0_1, 6'b0_0_0_0_1_0, 4'd4);
        row(5'b00001, 9'b1_1_0_0_0_1_1_0_1, 6'b0_0_0_0_1_0, 4'd3);
        row(5'b00001, 9'b1_1_0_0_0_1_1_0_1, 6'b0_0_0_1_1_0, 4'd2);
        row(5'b00001, 9'b1_1_0_0_0_1_0_0_1, 6'b0_0_0_1_1_0, 4'd1);
        row(5'b00001, 9'b1_0_0_0_0_0_0_1_1, 6'b0_1_0_1_1_0, 4'd0);
        row(5'b00000, 9'b1_0_0_0_0_0_0_0_0, 6'b0_1_0_1_1_1, 4'd0);
        // err_clr with no event
        row(5'b00100, 9'b1_0_0_0_0_0_0_0_0, 6'b0_1_0_1_1_1, 4'd0);
        row(5'b00000, 9'b1_0_0_0_0_0_0_0_0, 6'b0_1_0_1_0_0, 4'd0);

        set_in(5'b10000);
        adv();
        foreach (tbl[i]) begin
            set_in(tbl[i].in);
            @(negedge clk);
            chk($sformatf("vec%0d", i), {13'd0, outs()},
                {13'd0, tbl[i].exp});
            adv();
        end

        // concurrent push/pop from count 4
        set_in(5'b00010);
        repeat (4) adv();
        set_in(5'b00011);
        wclr_n = 0;
        rclr_n = 0;
        clash  = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            wclr_n += int'(bus.WrPtrClr);
            rclr_n += int'(bus.RdPtrClr);
            clash  += int'((bus.wren && bus.WrPtrClr)
                           || (bus.rden && bus.RdPtrClr));
            adv();
        end
        set_in(5'b00100);
        @(negedge clk);
        chk("conc_count", {28'd0, bus.count}, 32'd4);
        chk("conc_wstall", wclr_n, 32'd1);
        chk("conc_rstall", rclr_n, 32'd1);
        chk("conc_clash", clash, 32'd0);
        chk("conc_ovf", {31'd0, bus.overflow}, 32'd1);
        adv();

        // flush at count 5 with a push pending
        set_in(5'b00010);
        @(negedge clk);
        chk("errclr_ovf", {31'd0, bus.overflow}, 32'd0);
        adv();
        set_in(5'b01010);
        @(negedge clk);
        chk("flush_cnt5", {28'd0, bus.count}, 32'd5);
        chk("flush_wren", {30'd0, bus.wren, bus.push_ready}, 32'd0);
        adv();
        set_in(5'b00000);
        @(negedge clk);
        chk("flush_init", {13'd0, outs()}, {13'd0, rst_exp});
        adv();
        @(negedge clk);
        chk("flush_run", {31'd0, bus.push_ready}, 32'd1);
        adv();

        // underflow, then err_clr colliding with a new event
        set_in(5'b00001);
        @(negedge clk);
        chk("unf_pop_ready", {31'd0, bus.pop_ready}, 32'd0);
        adv();
        set_in(5'b00111);
        @(negedge clk);
        chk("empty_both", {30'd0, bus.wren, bus.rden}, 32'd2);
        adv();
        set_in(5'b00000);
        @(negedge clk);
        chk("unf_collide", {31'd0, bus.underflow}, 32'd1);
        chk("empty_both_cnt", {28'd0, bus.count}, 32'd1);

        // reset while the write wrap is pending
        set_in(5'b00010);
        repeat (7) adv();
        set_in(5'b10000);
        @(negedge clk);
        chk("wrap_pend", {27'd0, bus.WrPtrClr, bus.count}, 32'h18);
        adv();
        set_in(5'b00000);
        @(negedge clk);
        chk("rst_midwrap", {13'd0, outs()}, {13'd0, rst_exp});
        adv();
        @(negedge clk);
        chk("rst_run", {31'd0, bus.push_ready}, 32'd1);
        chk("rd_valid_total", rv_seen, 32'd17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
